// File: rtl/fib_scramble_sched.sv
// Two-requester round-robin scheduler sharing one Gray-code + Fibonacci-keystream scrambler.
// Latency: one cycle from accept to out_valid. The single-entry output register supports same-cycle drain and refill.
// Backpressure: no grant while the output is FULL with out_ready low, or while resync is high.
module fib_scramble_sched #(
  parameter int WIDTH  = 16,
  parameter int PERIOD = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             resync,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [15:0]      out_idx,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_e;

  localparam logic [15:0] K_LAST = 16'(PERIOD - 1);

  ostate_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [15:0]      k_q, k_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic [15:0]      idx_q, idx_d;

  logic             can_load;
  logic             grant;
  logic             gnt_sel;   // 0: requester 0, 1: requester 1
  logic [WIDTH-1:0] gnt_data;
  logic [WIDTH-1:0] gray;

  // Arbitration: pick a requester when the output slot can take a word
  always_comb begin
    can_load = (state_q == EMPTY) || out_ready;
    grant    = !rst && can_load && !resync && (req0_valid || req1_valid);
    gnt_sel  = (req0_valid && req1_valid) ? rr_q : req1_valid;
    gnt_data = gnt_sel ? req1_data : req0_data;
    gray     = gnt_data ^ (gnt_data >> 1);
  end

  // Output-slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Output-slot next state: a grant always refills; otherwise drain when consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = grant ? FULL : EMPTY;
      FULL:    state_d = (out_ready && !grant) ? EMPTY : FULL;
      default: state_d = EMPTY;
    endcase
  end

  // Output-slot outputs and requester handshakes
  always_comb begin
    out_valid  = (state_q == FULL);
    out_data   = data_q;
    out_src    = src_q;
    out_idx    = idx_q;
    req0_ready = grant && !gnt_sel;
    req1_ready = grant && gnt_sel;
  end

  // Keystream, round-robin pointer and result next-state
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    k_d    = k_q;
    rr_d   = rr_q;
    data_d = data_q;
    src_d  = src_q;
    idx_d  = idx_q;
    if (resync) begin
      a_d = '0;
      b_d = WIDTH'(1);
      k_d = '0;
    end else if (grant) begin
      data_d = a_q ^ gray;
      src_d  = gnt_sel;
      idx_d  = k_q;
      rr_d   = !gnt_sel;
      if (k_q == K_LAST) begin
        a_d = '0;
        b_d = WIDTH'(1);
        k_d = '0;
      end else begin
        a_d = b_q;
        b_d = a_q + b_q;   // wraps mod 2^WIDTH
        k_d = k_q + 16'd1;
      end
    end
  end

  // Keystream, pointer and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= WIDTH'(1);
      k_q    <= '0;
      rr_q   <= 1'b0;
      data_q <= '0;
      src_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      k_q    <= k_d;
      rr_q   <= rr_d;
      data_q <= data_d;
      src_q  <= src_d;
      idx_q  <= idx_d;
    end
  end

endmodule
